// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer: FSM encodings, flag bundle and a
// width helper.
package mode_sequencer_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_FLUSH  = 2'd1;
  localparam logic [ST_W-1:0] ST_COMMIT = 2'd2;

  typedef struct packed {
    logic flush_req;
    logic mode_changed;
    logic busy;
    logic timeout_err;
  } seq_flags_t;

  // Index width for n values, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Button inputs, flush handshake and mode/status outputs of the mode sequencer.
interface mode_sequencer_if #(
  parameter int unsigned N_MODES = 2
);
  import mode_sequencer_pkg::*;

  localparam int unsigned MODE_W = clog2_min1(N_MODES);

  logic              btn_next;
  logic              btn_prev;
  logic              lock;
  logic              flush_ack;
  logic [MODE_W-1:0] mode;
  logic [N_MODES-1:0] mode_onehot;
  logic              flush_req;
  logic              mode_changed;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  btn_next, btn_prev, lock, flush_ack,
    output mode, mode_onehot, flush_req, mode_changed, busy, timeout_err
  );

  modport slave (
    output btn_next, btn_prev, lock, flush_ack,
    input  mode, mode_onehot, flush_req, mode_changed, busy, timeout_err
  );

endinterface

// File: rtl/mode_sequencer_btn_debounce.sv
// Raw button -> 2-flop sync -> stable-level counter -> one-cycle press pulse.
module mode_sequencer_btn_debounce
  import mode_sequencer_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CNT_W = clog2_min1(DB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt_q;

  // Level flips only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        cnt_q <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Holds the active operating mode; next/prev presses step it with wrap, after a
// flush handshake (bounded by a timeout) with the engine being left.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int unsigned N_MODES     = 2,
  parameter int unsigned RST_MODE    = 0,
  parameter int unsigned DB_CYCLES   = 2000000,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input logic             clk,
  input logic             rst,
  mode_sequencer_if.master bus
);

  localparam int unsigned MODE_W = clog2_min1(N_MODES);
  localparam int unsigned TMO_W  = clog2_min1(ACK_TIMEOUT);
  localparam logic [MODE_W-1:0]  RST_IDX  = MODE_W'(RST_MODE);
  localparam logic [MODE_W-1:0]  LAST_IDX = MODE_W'(N_MODES - 1);
  localparam logic [N_MODES-1:0] RST_OH   = N_MODES'(1) << RST_MODE;

  logic [ST_W-1:0]    state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [MODE_W-1:0]  target_q, target_d;
  logic [N_MODES-1:0] oh_q, oh_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  seq_flags_t         flags_q, flags_d;
  logic               next_rise;
  logic               prev_rise;

  mode_sequencer_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_next_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_next),
    .rise (next_rise)
  );

  mode_sequencer_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_prev_db (
    .clk  (clk),
    .rst  (rst),
    .btn  (bus.btn_prev),
    .rise (prev_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= RST_IDX;
      target_q <= RST_IDX;
      oh_q     <= RST_OH;
      tmo_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      oh_q     <= oh_d;
      tmo_q    <= tmo_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state and registered-output values; edges outside IDLE are dropped.
  always_comb begin
    state_d              = state_q;
    mode_d               = mode_q;
    target_d             = target_q;
    oh_d                 = oh_q;
    tmo_d                = tmo_q;
    flags_d              = flags_q;
    flags_d.mode_changed = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.lock && (next_rise ^ prev_rise)) begin
          if (next_rise) target_d = (mode_q == LAST_IDX) ? '0 : mode_q + MODE_W'(1);
          else           target_d = (mode_q == '0) ? LAST_IDX : mode_q - MODE_W'(1);
          state_d           = ST_FLUSH;
          tmo_d             = '0;
          flags_d.flush_req = 1'b1;
          flags_d.busy      = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (bus.flush_ack || (tmo_q == TMO_W'(ACK_TIMEOUT - 1))) begin
          state_d              = ST_COMMIT;
          mode_d               = target_q;
          oh_d                 = N_MODES'(1) << target_q;
          flags_d.flush_req    = 1'b0;
          flags_d.mode_changed = 1'b1;
          if (!bus.flush_ack) flags_d.timeout_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d      = ST_IDLE;
        flags_d.busy = 1'b0;
      end
      default: begin
        state_d           = ST_IDLE;
        flags_d.flush_req = 1'b0;
        flags_d.busy      = 1'b0;
      end
    endcase
  end

  assign bus.mode         = mode_q;
  assign bus.mode_onehot  = oh_q;
  assign bus.flush_req    = flags_q.flush_req;
  assign bus.mode_changed = flags_q.mode_changed;
  assign bus.busy         = flags_q.busy;
  assign bus.timeout_err  = flags_q.timeout_err;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: scoreboard of expected modes checked on
// every mode_changed pulse, plus direct checks of flags and handshake timing.
module tb_mode_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mode_sequencer_if #(.N_MODES(N)) bus ();

  mode_sequencer #(
    .N_MODES    (N),
    .RST_MODE   (0),
    .DB_CYCLES  (4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int exp_mode;
  int sb_e;
  int nf;
  int ack_delay = 2;
  int req_cnt = 0;
  int n_flush = 0;
  int last_flush_len = 0;
  bit prev_mc = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic nx, input logic pv, input int hold);
    bus.btn_next = nx;
    bus.btn_prev = pv;
    repeat (hold) @(negedge clk);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
  endtask

  task automatic wait_flush(input string tag, input int budget);
    int k = 0;
    while (!bus.flush_req && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.flush_req), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},   32'(bus.mode), 0);
    check({tag, "_onehot"}, 32'(bus.mode_onehot), 1);
    check({tag, "_freq"},   32'(bus.flush_req), 0);
    check({tag, "_mc"},     32'(bus.mode_changed), 0);
    check({tag, "_busy"},   32'(bus.busy), 0);
    check({tag, "_terr"},   32'(bus.timeout_err), 0);
  endtask

  // Engine model: ack ack_delay cycles after flush_req (never if negative).
  always @(negedge clk) begin
    if (!rst || !bus.flush_req) begin
      if (rst && req_cnt != 0) last_flush_len = req_cnt;
      req_cnt       = 0;
      bus.flush_ack = 1'b0;
    end else begin
      req_cnt++;
      if (req_cnt == 1) n_flush++;
      bus.flush_ack = (ack_delay >= 0) && (req_cnt > ack_delay);
    end
  end

  // Scoreboard: each mode_changed pulse consumes one expected mode.
  always @(negedge clk) begin
    if (bus.mode_changed) begin
      check("mc_single", 32'(prev_mc), 0);
      check("sb_pending", 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) begin
        sb_e = exp_q.pop_front();
        check("sb_mode", 32'(bus.mode), 32'(sb_e));
        check("sb_onehot", 32'(bus.mode_onehot), 32'(1 << sb_e));
      end
    end
    prev_mc = bus.mode_changed;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.lock     = 1'b0;
    #3 rst = 1'b0;
    settle(2);
    check_reset_vals("rst");
    rst = 1'b1;
    exp_mode = 0;
    settle(3);

    // Three next presses: 0->1->2->0
    repeat (3) begin
      exp_mode = (exp_mode == N - 1) ? 0 : exp_mode + 1;
      exp_q.push_back(exp_mode);
      press(1'b1, 1'b0, 10);
      settle(15);
      check("t2_mode", 32'(bus.mode), 32'(exp_mode));
      check("t2_flush_len", 32'(last_flush_len), 3);
    end
    check("t2_nflush", 32'(n_flush), 3);

    // Async reset mid-cycle from mode 1
    exp_q.push_back(1);
    press(1'b1, 1'b0, 10);
    settle(15);
    check("t1_pre_mode", 32'(bus.mode), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("t1");
    settle(2);
    rst = 1'b1;
    settle(3);

    // prev wraps 0 -> 2, then a short bounce changes nothing
    exp_q.push_back(2);
    press(1'b0, 1'b1, 10);
    settle(15);
    check("t3_mode", 32'(bus.mode), 2);
    nf = n_flush;
    press(1'b1, 1'b0, 3);
    settle(1);
    press(1'b1, 1'b0, 2);
    settle(15);
    check("t3_bounce_nflush", 32'(n_flush), 32'(nf));
    check("t3_bounce_mode", 32'(bus.mode), 2);

    // No ack: timeout after exactly 8 flush cycles, 2 -> 0
    ack_delay = -1;
    exp_q.push_back(0);
    bus.btn_next = 1'b1;
    wait_flush("t4_req", 20);
    check("t4_busy", 32'(bus.busy), 1);
    settle(10);
    bus.btn_next = 1'b0;
    settle(15);
    check("t4_flush_len", 32'(last_flush_len), 8);
    check("t4_terr", 32'(bus.timeout_err), 1);
    check("t4_mode", 32'(bus.mode), 0);
    check("t4_busy_after", 32'(bus.busy), 0);
    ack_delay = 2;

    // Simultaneous edges and locked presses are discarded
    nf = n_flush;
    press(1'b1, 1'b1, 10);
    settle(15);
    check("t5_both_nflush", 32'(n_flush), 32'(nf));
    bus.lock = 1'b1;
    press(1'b1, 1'b0, 10);
    settle(10);
    bus.lock = 1'b0;
    settle(5);
    check("t5_lock_nflush", 32'(n_flush), 32'(nf));
    check("t5_lock_mode", 32'(bus.mode), 0);

    // A prev press landing during FLUSH is dropped: only 0 -> 1
    ack_delay = 6;
    exp_q.push_back(1);
    bus.btn_next = 1'b1;
    wait_flush("t5_req", 20);
    bus.btn_prev = 1'b1;
    settle(10);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    settle(20);
    check("t5_drop_nflush", 32'(n_flush), 32'(nf + 1));
    check("t5_drop_mode", 32'(bus.mode), 1);
    check("t5_terr_sticky", 32'(bus.timeout_err), 1);

    // Reset during FLUSH: back to reset values, no mode_changed
    ack_delay = -1;
    bus.btn_next = 1'b1;
    wait_flush("t6_req", 20);
    settle(2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("t6");
    bus.btn_next = 1'b0;
    settle(10);
    rst = 1'b1;
    settle(10);
    check("t6_mode_after", 32'(bus.mode), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
